// File: rtl/lc3b_types.sv
// Shared LC-3b types: register index, pipeline-slot record and operand routing code.
package lc3b_types;

  typedef logic [2:0] lc3b_reg;

  // {opA source, opB source}: 1 selects WB, 0 selects MEM
  typedef enum logic [1:0] {
    CC_MEM_MEM = 2'b00,
    CC_MEM_WB  = 2'b01,
    CC_WB_MEM  = 2'b10,
    CC_WB_WB   = 2'b11
  } curr_case_e;

  typedef struct packed {
    lc3b_reg dr;
    logic    regwrite;
    logic    is_load;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '0;

endpackage

// File: rtl/forward_ctrl_fwd_match.sv
// Per-operand match of one EX source register against the MEM and WB destinations.
module fwd_match
  import lc3b_types::*;
(
  input  lc3b_reg sr,
  input  logic    sr_valid,
  input  lc3b_reg mem_dr,
  input  logic    mem_regwrite,
  input  lc3b_reg wb_dr,
  input  logic    wb_regwrite,
  output logic    match_mem,
  output logic    match_wb
);

  assign match_mem = sr_valid & mem_regwrite & (sr == mem_dr);
  assign match_wb  = sr_valid & wb_regwrite  & (sr == wb_dr);

endmodule

// File: rtl/forward_ctrl.sv
// Forwarding and load-use stall control: tracks MEM/WB destinations, routes operands,
// inserts one bubble per load-use hazard and counts those stalls.
module forward_ctrl
  import lc3b_types::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 advance,
  input  logic [2:0]           ex_sr1,
  input  logic [2:0]           ex_sr2,
  input  logic                 ex_sr1_valid,
  input  logic                 ex_sr2_valid,
  input  logic [2:0]           ex_dr,
  input  logic                 ex_regwrite,
  input  logic                 ex_is_load,
  output logic [1:0]           curr_case,
  output logic                 fwd_a,
  output logic                 fwd_b,
  output logic                 stall,
  output logic [CNT_WIDTH-1:0] stall_count
);

  typedef enum logic {
    RUN       = 1'b0,
    LU_BUBBLE = 1'b1
  } state_e;

  state_e     state;
  slot_t      mem_slot;
  slot_t      wb_slot;
  logic       a_mem, a_wb, b_mem, b_wb;
  logic       lu_hazard;
  curr_case_e cc_sel;

  fwd_match u_match_a (
    .sr           (ex_sr1),
    .sr_valid     (ex_sr1_valid),
    .mem_dr       (mem_slot.dr),
    .mem_regwrite (mem_slot.regwrite),
    .wb_dr        (wb_slot.dr),
    .wb_regwrite  (wb_slot.regwrite),
    .match_mem    (a_mem),
    .match_wb     (a_wb)
  );

  fwd_match u_match_b (
    .sr           (ex_sr2),
    .sr_valid     (ex_sr2_valid),
    .mem_dr       (mem_slot.dr),
    .mem_regwrite (mem_slot.regwrite),
    .wb_dr        (wb_slot.dr),
    .wb_regwrite  (wb_slot.regwrite),
    .match_mem    (b_mem),
    .match_wb     (b_wb)
  );

  assign lu_hazard = mem_slot.is_load & (a_mem | b_mem);

  always_comb begin
    cc_sel    = curr_case_e'({a_wb & ~a_mem, b_wb & ~b_mem});
    fwd_a     = a_mem | a_wb;
    fwd_b     = b_mem | b_wb;
    stall     = (state == RUN) & lu_hazard;
  end

  assign curr_case = cc_sel;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_slot    <= SLOT_BUBBLE;
      wb_slot     <= SLOT_BUBBLE;
      state       <= RUN;
      stall_count <= '0;
    end else if (advance) begin
      wb_slot  <= mem_slot;
      mem_slot <= stall ? SLOT_BUBBLE : slot_t'{dr: ex_dr, regwrite: ex_regwrite, is_load: ex_is_load};
      case (state)
        RUN: if (lu_hazard) begin
          state <= LU_BUBBLE;
          if (stall_count != '1) stall_count <= stall_count + 1'b1;
        end
        LU_BUBBLE: state <= RUN;
        default:   state <= RUN;
      endcase
    end
  end

  // While bubbling, the stalled load sits in WB and is forwarded from there.
  always_comb begin
    if (rst_n && state == LU_BUBBLE) assert (wb_slot.is_load);
  end

endmodule

// File: doc/forward_ctrl.md
FORWARD_CTRL -- requirements
Module: forward_ctrl

Interface
REQ-001 Parameter: CNT_WIDTH, 16, width of the load-use stall counter.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  synchronous, active-low reset.
REQ-004 advance  in  1  pipeline moves one stage this cycle (from global pipeline control).
REQ-005 ex_sr1, ex_sr2  in  3 each  source registers of the instruction in EX.
REQ-006 ex_sr1_valid, ex_sr2_valid  in  1 each  the source is actually read.
REQ-007 ex_dr  in  3  destination register of the instruction in EX.
REQ-008 ex_regwrite  in  1  EX instruction writes ex_dr.
REQ-009 ex_is_load  in  1  EX instruction is LDB/LDR/LDI.
REQ-010 curr_case  out  2  operand routing code to the downstream operand selector: bit1=1 means opA from WB, else MEM; bit0=1 means opB from WB, else MEM.
REQ-011 fwd_a, fwd_b  out  1 each  operand A/B takes forwarded data instead of register-file data.
REQ-012 stall  out  1  hold IF/ID/EX and inject a bubble into MEM.
REQ-013 stall_count  out  CNT_WIDTH  number of load-use stalls since reset.

Function
REQ-014 Internal MEM slot and WB slot SHALL each hold {dr, regwrite, is_load}; these track the instructions in MEM and WB.
REQ-015 On a clock with advance=1 and stall=0: MEM slot <= {ex_dr, ex_regwrite, ex_is_load}; WB slot <= MEM slot.
REQ-016 On a clock with advance=1 and stall=1: MEM slot <= bubble (regwrite=0, is_load=0); WB slot <= MEM slot.
REQ-017 With advance=0, both slots and the FSM SHALL hold.
REQ-018 Match A (MEM) = ex_sr1_valid & MEM.regwrite & (ex_sr1==MEM.dr); likewise for WB and for operand B with ex_sr2.
REQ-019 fwd_a = Match A (MEM) | Match A (WB); fwd_b is defined likewise; combinational.
REQ-020 Priority: MEM over WB; curr_case[1] = Match A (WB) & ~Match A (MEM); curr_case[0] is defined likewise for B.
REQ-021 When an operand is not forwarded, its curr_case bit SHALL be 0.
REQ-022 lu_hazard = MEM.is_load & (Match A (MEM) | Match B (MEM)).
REQ-023 FSM states: RUN, LU_BUBBLE.
REQ-024 In RUN, stall = lu_hazard, combinational, independent of advance.
REQ-025 In LU_BUBBLE, stall = 0.
REQ-026 Transition RUN->LU_BUBBLE on advance & lu_hazard.
REQ-027 Transition LU_BUBBLE->RUN on advance.
REQ-028 All other conditions hold the current state.
REQ-029 In LU_BUBBLE the load has moved to WB, and REQ-020 then routes it from WB; forwarding SHALL need no special case.
REQ-030 stall_count SHALL increment on each RUN->LU_BUBBLE transition and saturate at all-ones.
REQ-031 R0 is a normal register and SHALL receive no zero-register exemption.

Reset
REQ-032 When rst_n=0 at a rising edge: both slots become bubbles, the FSM enters RUN and stall_count=0, overriding advance.
REQ-033 After reset, with any EX inputs: curr_case=00, fwd_a=0, fwd_b=0, stall=0.
REQ-034 Reset asserted while in LU_BUBBLE SHALL return the FSM to RUN with no residual stall.

Structure
REQ-035 lc3b_reg (3-bit) and the curr_case encoding typedef SHALL live in the shared lc3b_types package.
REQ-036 The FSM state enum SHALL be local to the module.
REQ-037 One sub-module, fwd_match, SHALL compute the MEM/WB match bits for one operand; it is instantiated twice (A, B).
REQ-038 The block SHALL contain no memories or latches; only the two slots, the state register and the counter are registered.

Verification
REQ-039 Reset, then EX sr1=3 and sr2=4 (both valid) with empty slots -> curr_case=00, fwd_a=0, fwd_b=0, stall=0.
REQ-040 ADD R2 (regwrite) advanced into MEM, then EX sr1=2 and sr2=5 -> fwd_a=1, curr_case=00, stall=0; one further advance with a non-writing EX instruction -> curr_case=10, fwd_a=1.
REQ-041 R2 in both MEM and WB (back-to-back writers), EX sr2=2 -> fwd_b=1, curr_case[0]=0 (MEM wins).
REQ-042 LDR R1 in MEM, EX sr1=1 -> stall=1; after one advance -> state LU_BUBBLE, stall=0, MEM slot bubble, curr_case=10, fwd_a=1, stall_count=1.
REQ-043 Load-use hazard with advance=0 for 3 cycles -> stall stays 1, slots unchanged, stall_count stays 0; then advance=1 -> stall_count=1.
REQ-044 rst_n=0 asserted while in LU_BUBBLE with stall_count=5 -> next cycle RUN, stall_count=0, all outputs 0.
